data_mem_responder: RTL and testbench

Data-memory responder for the pipeline's load/store port. It services `wr`/`rd` requests on the core's 9-bit byte-addressed data interface and returns `rd_data`. It adds a configurable wait-state sequencer with `busy`/`done` handshake so the Datapath can stall. Byte, halfword and word accesses are selected by `funct3`, and misaligned or illegal accesses are flagged.

---
 rtl/data_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-addressed load/store responder for the pipeline's
// data port. Accepts one request in IDLE, waits a programmable number of
// cycles, then completes in a single RESP cycle with done/err and, for legal
// loads, a formatted rd_data. Storage is word-organised with byte lanes.
module data_mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int WORDS = 2 ** (ADDR_W - 2);
  // WAIT_STATES of 0 and 1 both spend a single cycle in WAIT, so the
  // accept-to-RESP distance is max(WAIT_STATES, 1) edges.
  localparam logic [2:0] CNT_INIT = (WAIT_STATES > 1) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t            state;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] d_q;
  logic [2:0]        f_q;
  logic              op_wr;
  logic              op_both;

  logic [31:0] mem [WORDS];

  logic [ADDR_W-3:0] idx;
  logic [1:0]        off;
  logic              commit;
  logic              legal;
  logic [31:0]       word;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       load_val;
  logic [3:0]        be;
  logic [31:0]       wdata;

  assign idx    = a_q[ADDR_W-1:2];
  assign off    = a_q[1:0];
  assign commit = (state == WAIT) && (cnt == 3'd0);

  // Legality of the captured access: size allowed for the op and aligned.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    legal = 1'b0;
    case (f_q)
      3'b000:         legal = 1'b1;
      3'b001:         legal = ~off[0];
      3'b010:         legal = (off == 2'b00);
      3'b100, 3'b101: legal = ~op_wr & (~f_q[0] | ~off[0]);
      default:        legal = 1'b0;
    endcase
    if (op_both) legal = 1'b0;
  end

  // Little-endian extraction and sign/zero extension of the load result.
  always_comb begin
    word     = mem[idx];
    byte_v   = word[{off, 3'b000} +: 8];
    half_v   = off[1] ? word[31:16] : word[15:0];
    load_val = word;
    case (f_q)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_val = {24'd0, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b101:  load_val = {16'd0, half_v};
      default: load_val = word;
    endcase
  end

  // Byte-lane enables and replicated store data for SB/SH/SW.
  always_comb begin
    be    = 4'b1111;
    wdata = d_q;
    case (f_q[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{d_q[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{d_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = d_q;
      end
    endcase
  end

  // Store commit on the edge entering RESP; an aborting reset suppresses it.
  // NOTE: storage has no reset; clearing a RAM array would defeat RAM inference.
  always_ff @(posedge clk) begin
    if (!reset && commit && op_wr && legal) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Request sequencer: capture in IDLE, count in WAIT, single-cycle RESP.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      a_q     <= '0;
      d_q     <= '0;
      f_q     <= 3'd0;
      op_wr   <= 1'b0;
      op_both <= 1'b0;
      rd_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr | rd) begin
            a_q     <= addr;
            d_q     <= wr_data;
            f_q     <= funct3;
            op_wr   <= wr;
            op_both <= wr & rd;
            cnt     <= CNT_INIT;
            busy    <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state <= RESP;
            done  <= 1'b1;
            err   <= ~legal;
            if (!op_wr && legal) rd_data <= load_val;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (WAIT_STATES 1, 0
// and 7) share stimulus buses; sel routes requests to one instance at a time.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic        rd;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic [2:0]  funct3;
  logic [2:0]  sel;

  logic [31:0] rd_data_1, rd_data_0, rd_data_7, rd_data_s;
  logic        busy_1, busy_0, busy_7, busy_s;
  logic        done_1, done_0, done_7, done_s;
  logic        err_1, err_0, err_7, err_s;

  int errors = 0;
  int checks = 0;
  int done_count = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .wr(wr & sel[0]), .rd(rd & sel[0]), .addr(addr),
    .wr_data(wr_data), .funct3(funct3), .rd_data(rd_data_1), .busy(busy_1),
    .done(done_1), .err(err_1)
  );

  data_mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .wr(wr & sel[1]), .rd(rd & sel[1]), .addr(addr),
    .wr_data(wr_data), .funct3(funct3), .rd_data(rd_data_0), .busy(busy_0),
    .done(done_0), .err(err_0)
  );

  data_mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(7)) u_ws7 (
    .clk(clk), .reset(reset), .wr(wr & sel[2]), .rd(rd & sel[2]), .addr(addr),
    .wr_data(wr_data), .funct3(funct3), .rd_data(rd_data_7), .busy(busy_7),
    .done(done_7), .err(err_7)
  );

  // View of the currently selected instance.
  always_comb begin
    rd_data_s = rd_data_1;
    busy_s    = busy_1;
    done_s    = done_1;
    err_s     = err_1;
    case (sel)
      3'b010: begin
        rd_data_s = rd_data_0; busy_s = busy_0; done_s = done_0; err_s = err_0;
      end
      3'b100: begin
        rd_data_s = rd_data_7; busy_s = busy_7; done_s = done_7; err_s = err_7;
      end
      default: ;
    endcase
  end

  // Counts RESP cycles of the selected instance.
  always @(posedge clk) begin
    if (done_s) done_count <= done_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on the selected instance; checks latency, err, rd_data and the
  // return to idle.
  task automatic access(input string tag, input logic w, input logic r,
                        input logic [8:0] a, input logic [31:0] d, input logic [2:0] f,
                        input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
    int lat;
    @(negedge clk);
    wr = w; rd = r; addr = a; wr_data = d; funct3 = f;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    check({tag, " busy"}, 32'(busy_s), 32'd1);
    lat = 0;
    while (!done_s && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " err"}, 32'(err_s), 32'(exp_err));
    check({tag, " rd_data"}, rd_data_s, exp_rd);
    @(posedge clk); #1;
    check({tag, " idle"}, 32'({busy_s, done_s, err_s}), 32'd0);
  endtask

  initial begin
    int base;
    reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0; funct3 = '0;
    sel = 3'b001;
    repeat (2) @(posedge clk);
    #1;
    check("reset rd_data", rd_data_s, 32'h0);
    check("reset busy", 32'(busy_s), 32'd0);
    check("reset done", 32'(done_s), 32'd0);
    check("reset err", 32'(err_s), 32'd0);
    @(negedge clk) reset = 1'b0;

    // WAIT_STATES = 1
    access("sw 010 preload", 1'b1, 1'b0, 9'h010, 32'h0000_0000, 3'b010, 1, 1'b0, 32'h0);
    access("sw 020", 1'b1, 1'b0, 9'h020, 32'h8081_7F01, 3'b010, 1, 1'b0, 32'h0);
    access("lw 020", 1'b0, 1'b1, 9'h020, 32'h0, 3'b010, 1, 1'b0, 32'h8081_7F01);

    // Reset in the middle of WAIT for a store: aborted, nothing written.
    @(negedge clk);
    wr = 1'b1; addr = 9'h010; wr_data = 32'hDEAD_BEEF; funct3 = 3'b010;
    @(posedge clk); #1;
    wr = 1'b0;
    check("abort pre busy", 32'(busy_s), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort rd_data", rd_data_s, 32'h0);
    check("abort busy", 32'(busy_s), 32'd0);
    check("abort done err", 32'({done_s, err_s}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    access("lw 010 after abort", 1'b0, 1'b1, 9'h010, 32'h0, 3'b010, 1, 1'b0, 32'h0000_0000);

    access("lb 023",  1'b0, 1'b1, 9'h023, 32'h0, 3'b000, 1, 1'b0, 32'hFFFF_FF80);
    access("lbu 023", 1'b0, 1'b1, 9'h023, 32'h0, 3'b100, 1, 1'b0, 32'h0000_0080);
    access("lh 022",  1'b0, 1'b1, 9'h022, 32'h0, 3'b001, 1, 1'b0, 32'hFFFF_8081);
    access("lhu 020", 1'b0, 1'b1, 9'h020, 32'h0, 3'b101, 1, 1'b0, 32'h0000_7F01);
    access("sb 021",  1'b1, 1'b0, 9'h021, 32'h0000_00AA, 3'b000, 1, 1'b0, 32'h0000_7F01);
    access("lw 020 after sb", 1'b0, 1'b1, 9'h020, 32'h0, 3'b010, 1, 1'b0, 32'h8081_AA01);

    // Illegal accesses: err with done, rd_data held, no memory effect.
    access("lw 022 misaligned", 1'b0, 1'b1, 9'h022, 32'h0, 3'b010, 1, 1'b1, 32'h8081_AA01);
    access("sh 021 misaligned", 1'b1, 1'b0, 9'h021, 32'h0000_5555, 3'b001, 1, 1'b1, 32'h8081_AA01);
    access("lw 020 after bad sh", 1'b0, 1'b1, 9'h020, 32'h0, 3'b010, 1, 1'b0, 32'h8081_AA01);
    access("wr and rd", 1'b1, 1'b1, 9'h020, 32'h1111_1111, 3'b010, 1, 1'b1, 32'h8081_AA01);
    access("load f3 011", 1'b0, 1'b1, 9'h020, 32'h0, 3'b011, 1, 1'b1, 32'h8081_AA01);
    access("sbu store", 1'b1, 1'b0, 9'h020, 32'h0000_0022, 3'b100, 1, 1'b1, 32'h8081_AA01);
    access("lw 020 unchanged", 1'b0, 1'b1, 9'h020, 32'h0, 3'b010, 1, 1'b0, 32'h8081_AA01);
    access("lhu 022", 1'b0, 1'b1, 9'h022, 32'h0, 3'b101, 1, 1'b0, 32'h0000_8081);

    // WAIT_STATES = 0
    sel = 3'b010;
    access("ws0 sw 004", 1'b1, 1'b0, 9'h004, 32'h1234_5678, 3'b010, 1, 1'b0, 32'h0);
    access("ws0 lb 005", 1'b0, 1'b1, 9'h005, 32'h0, 3'b000, 1, 1'b0, 32'h0000_0056);

    // WAIT_STATES = 7
    sel = 3'b100;
    access("ws7 sw 008", 1'b1, 1'b0, 9'h008, 32'hCAFE_F00D, 3'b010, 7, 1'b0, 32'h0);
    access("ws7 lh 00a", 1'b0, 1'b1, 9'h00A, 32'h0, 3'b001, 7, 1'b0, 32'hFFFF_CAFE);

    // rd toggling during WAIT is ignored: exactly one completion.
    base = done_count;
    @(negedge clk);
    rd = 1'b1; addr = 9'h008; funct3 = 3'b010;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rd = ~rd;
    end
    rd = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("ws7 toggle done count", 32'(done_count - base), 32'd1);
    check("ws7 toggle rd_data", rd_data_s, 32'hCAFE_F00D);
    check("ws7 toggle idle", 32'({busy_s, done_s}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
